// File: rtl/dcache_controller_pkg.sv
// Shared types and geometry for the two-way write-through data cache.
// Address split helpers map a byte address onto the 17-bit SRAM word space.
package dcache_controller_pkg;

    localparam logic [31:0] BASE_ADDR = 32'd1024;
    localparam int IDX_W    = 6;
    localparam int TAG_W    = 11;
    localparam int WORD_W   = IDX_W + TAG_W;
    localparam int NUM_SETS = 1 << IDX_W;
    localparam int NUM_WAYS = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] word_addr(input logic [31:0] byte_addr);
        return WORD_W'((byte_addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] byte_addr);
        logic [WORD_W-1:0] w;
        w = word_addr(byte_addr);
        return w[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] byte_addr);
        logic [WORD_W-1:0] w;
        w = word_addr(byte_addr);
        return w[WORD_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// Bus bundles for the cache: MEM-stage request side and SRAM_Controller side.
// The master modport belongs to whoever initiates requests on that bus.
interface dcache_mem_if;
    logic        memRdEn;
    logic        memWrEn;
    logic [31:0] address;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        ready;

    modport master (output memRdEn, memWrEn, address, wrData, input rdData, ready);
    modport slave  (input memRdEn, memWrEn, address, wrData, output rdData, ready);
endinterface

interface dcache_sram_if;
    logic        sramRdEn;
    logic        sramWrEn;
    logic [31:0] sramAddress;
    logic [31:0] sramWrData;
    logic [31:0] sramRdData;
    logic        sramReady;

    modport master (output sramRdEn, sramWrEn, sramAddress, sramWrData,
                    input sramRdData, sramReady);
    modport slave  (input sramRdEn, sramWrEn, sramAddress, sramWrData,
                    output sramRdData, sramReady);
endinterface

// File: rtl/dcache_controller_cache_memory.sv
// Valid/tag/data storage for two ways plus per-set LRU bit.
// Lookup is combinational on index/tag; all updates land on the clock edge.
module cache_memory
    import dcache_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    input  logic             acc_en,
    input  logic             acc_way,
    input  logic             fill_en,
    input  logic             data_en,
    input  logic [31:0]      wdata,
    output logic             hit,
    output logic             hit_way,
    output logic [31:0]      hit_data,
    output logic [NUM_WAYS-1:0] valid_set,
    output logic             lru_way
);

    logic [NUM_WAYS-1:0] way_hit;
    logic [31:0]         way_data [NUM_WAYS];
    logic [NUM_SETS-1:0] lru_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            localparam logic WAY = 1'(gi);
            logic [NUM_SETS-1:0] valid_reg;
            logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
            logic [31:0]         data_mem [NUM_SETS];
            logic                sel;

            assign sel = (acc_way == WAY);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= '0;
                end else if (fill_en && sel) begin
                    valid_reg[index] <= 1'b1;
                end
            end

            // Tag and data need no reset: nothing reads them until valid is set.
            always_ff @(posedge clk) begin
                if (fill_en && sel) begin
                    tag_mem[index] <= tag;
                end
                if (data_en && sel) begin
                    data_mem[index] <= wdata;
                end
            end

            assign valid_set[gi] = valid_reg[index];
            assign way_hit[gi]   = valid_reg[index] && (tag_mem[index] == tag);
            assign way_data[gi]  = data_mem[index];
        end
    endgenerate

    // lru_reg[set] names the victim way, so an access to way w leaves ~w behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_reg <= '0;
        end else if (acc_en) begin
            lru_reg[index] <= ~acc_way;
        end
    end

    assign hit      = |way_hit;
    assign hit_way  = way_hit[1];
    assign hit_data = way_hit[1] ? way_data[1] : way_data[0];
    assign lru_way  = lru_reg[index];

endmodule

// File: rtl/dcache_controller.sv
// Two-way set-associative write-through, no-write-allocate data cache.
// Read hits finish in the request cycle; misses and writes stall via ready.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dcache_mem_if.slave  mem,
    dcache_sram_if.master sram
);

    state_t state_reg;
    state_t state_next;

    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                hit_way;
    logic [31:0]         hit_data;
    logic [NUM_WAYS-1:0] valid_set;
    logic                lru_way;
    logic                victim;

    logic                acc_en;
    logic                acc_way;
    logic                fill_en;
    logic                data_en;
    logic [31:0]         wdata;

    assign index = addr_index(mem.address);
    assign tag   = addr_tag(mem.address);

    cache_memory u_mem (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .acc_en    (acc_en),
        .acc_way   (acc_way),
        .fill_en   (fill_en),
        .data_en   (data_en),
        .wdata     (wdata),
        .hit       (hit),
        .hit_way   (hit_way),
        .hit_data  (hit_data),
        .valid_set (valid_set),
        .lru_way   (lru_way)
    );

    // Fill an empty way first (way 0 before way 1); only evict when both are live.
    assign victim = !valid_set[0] ? 1'b0 :
                    !valid_set[1] ? 1'b1 : lru_way;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem.ready  = 1'b0;
        mem.rdData = hit_data;
        acc_en     = 1'b0;
        acc_way    = hit_way;
        fill_en    = 1'b0;
        data_en    = 1'b0;
        wdata      = mem.wrData;
        case (state_reg)
            IDLE: begin
                if (mem.memWrEn) begin
                    state_next = WRITE;
                end else if (mem.memRdEn) begin
                    if (hit) begin
                        mem.ready = 1'b1;
                        acc_en    = 1'b1;
                    end else begin
                        state_next = READ_MISS;
                    end
                end else begin
                    mem.ready = 1'b1;
                end
            end
            READ_MISS: begin
                if (sram.sramReady) begin
                    mem.ready  = 1'b1;
                    mem.rdData = sram.sramRdData;
                    acc_en     = 1'b1;
                    acc_way    = victim;
                    fill_en    = 1'b1;
                    data_en    = 1'b1;
                    wdata      = sram.sramRdData;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                if (sram.sramReady) begin
                    mem.ready = 1'b1;
                    if (hit) begin
                        acc_en  = 1'b1;
                        data_en = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Requests are decoded from state alone so they drop the cycle after sramReady.
    assign sram.sramRdEn    = (state_reg == READ_MISS);
    assign sram.sramWrEn    = (state_reg == WRITE);
    assign sram.sramAddress = mem.address;
    assign sram.sramWrData  = mem.wrData;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a fixed-latency SRAM_Controller model.
module tb_dcache_controller;

    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_mem_if  mem_bus ();
    dcache_sram_if sram_bus ();

    dcache_controller dut (
        .clk  (clk),
        .rst  (rst),
        .mem  (mem_bus),
        .sram (sram_bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        hit;
        logic        is_wr;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        hit;
    } stim_t;

    exp_t        exp_q [$];
    logic [31:0] gmem [int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt = 0;

    function automatic logic [31:0] gval(input logic [31:0] a);
        if (gmem.exists(int'(a))) return gmem[int'(a)];
        return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM_Controller model: raises ready for one cycle after LAT cycles of request.
    always @(negedge clk) begin
        if (rst || !(sram_bus.sramRdEn || sram_bus.sramWrEn) || sram_bus.sramReady) begin
            sram_bus.sramReady = 1'b0;
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == LAT) begin
                sram_bus.sramReady = 1'b1;
                if (sram_bus.sramRdEn)
                    sram_bus.sramRdData = gval(sram_bus.sramAddress);
                else
                    gmem[int'(sram_bus.sramAddress)] = sram_bus.sramWrData;
            end
        end
    end

    task automatic do_req(input int id, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
        exp_t e;
        int   cyc;
        logic saw_rd;
        logic saw_wr;
        @(negedge clk);
        chk("idle_rden", 32'(sram_bus.sramRdEn), 32'd0);
        chk("idle_wren", 32'(sram_bus.sramWrEn), 32'd0);
        mem_bus.memRdEn = rd;
        mem_bus.memWrEn = wr;
        mem_bus.address = a;
        mem_bus.wrData  = d;
        exp_q.push_back('{addr: a, data: (wr ? d : gval(a)), hit: exp_hit, is_wr: wr});
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        cyc = 0;
        #1;
        while (!mem_bus.ready && cyc < 100) begin
            saw_rd |= sram_bus.sramRdEn;
            saw_wr |= sram_bus.sramWrEn;
            @(negedge clk);
            #1;
            cyc++;
        end
        saw_rd |= sram_bus.sramRdEn;
        saw_wr |= sram_bus.sramWrEn;
        chk("ready_timeout", 32'(mem_bus.ready), 32'd1);
        e = exp_q.pop_front();
        if (e.is_wr) begin
            chk("wr_sramWrEn", 32'(saw_wr), 32'd1);
            chk("wr_no_sramRdEn", 32'(saw_rd), 32'd0);
            chk("wr_sramWrData", sram_bus.sramWrData, e.data);
            chk("wr_sramAddress", sram_bus.sramAddress, e.addr);
        end else begin
            chk("rd_data", mem_bus.rdData, e.data);
            chk("rd_hit", 32'(cyc == 0), 32'(e.hit));
            if (e.hit)
                chk("hit_no_sram", 32'(saw_rd | saw_wr), 32'd0);
            else
                chk("miss_sramAddress", sram_bus.sramAddress, e.addr);
        end
        $display("txn %0d rd=%0b wr=%0b addr=%0d rdData=%h cycles=%0d", id, rd, wr, a,
                 mem_bus.rdData, cyc);
    endtask

    stim_t tbl [14];

    initial begin
        gmem[1024] = 32'hDEAD_BEEF;
        sram_bus.sramReady  = 1'b0;
        sram_bus.sramRdData = '0;
        mem_bus.memRdEn = 1'b0;
        mem_bus.memWrEn = 1'b0;
        mem_bus.address = 32'd1024;
        mem_bus.wrData  = '0;

        tbl[0]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b1};
        tbl[2]  = '{1'b0, 1'b1, 32'd1024, 32'h0000_1234, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'd1280, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'd1536, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b1};
        tbl[8]  = '{1'b1, 1'b0, 32'd1280, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'd2048, 32'hCAFE_0001, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'd2048, 32'h0,         1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'd1024, 32'h5555_AAAA, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'd1024, 32'h0,         1'b1};

        #1;
        chk("reset_ready", 32'(mem_bus.ready), 32'd1);
        chk("reset_rden", 32'(sram_bus.sramRdEn), 32'd0);
        chk("reset_wren", 32'(sram_bus.sramWrEn), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            do_req(i, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].hit);

        // Reset in the middle of a read miss.
        @(negedge clk);
        mem_bus.memRdEn = 1'b1;
        mem_bus.memWrEn = 1'b0;
        mem_bus.address = 32'd4096;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_rden", 32'(sram_bus.sramRdEn), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_rden_async", 32'(sram_bus.sramRdEn), 32'd0);
        chk("rst_ready_req", 32'(mem_bus.ready), 32'd0);
        @(negedge clk);
        mem_bus.memRdEn = 1'b0;
        #1;
        chk("rst_ready_idle", 32'(mem_bus.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_req(14, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);

        @(negedge clk);
        mem_bus.memRdEn = 1'b0;
        mem_bus.memWrEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
